// File: rtl/rgmii_rx_framer.sv
// -----------------------------------------------------------------------------
// rgmii_rx_framer
//
// Receive-side GMII framer. It sits behind an RGMII-to-GMII converter and turns
// the byte stream into a framed stream with the preamble, the SFD and the FCS
// removed. Each frame ends with a single error flag, and the block counts good
// and bad frames.
//
// The FCS is dropped without a separate length field. Every byte after the SFD
// goes into a 5-byte delay line, and a byte leaves the line only when a newer
// byte pushes it out. When rxdv falls, the line holds the last payload byte
// (the oldest entry) and the 4 FCS bytes. The framer emits the last payload
// byte with m_eof and discards the rest.
//
// Optional feature macro: RGMII_RX_CRC_CHECK_EN
//   defined   : CRC-32 (reflected 0xEDB88320, init 0xFFFFFFFF) runs over every
//               byte after the SFD, FCS included. crc_err is raised at m_eof
//               when the residue is not 0xDEBB20E3.
//   undefined : no CRC logic is built and crc_err is tied low.
//
// Parameters
//   MIN_LEN    shortest acceptable frame, in bytes after the SFD, FCS included
//   MAX_LEN    longest acceptable frame, in bytes after the SFD, FCS included
//
// Ports
//   clk_div    GMII receive clock (125 / 25 / 2.5 MHz)
//   reset      asynchronous reset, active-high
//   rxd        GMII receive data
//   rxdv       GMII data valid
//   rxer       GMII receive error
//   ibs_up     in-band link status (1 = link up)
//   m_data     frame byte (0 when m_valid = 0)
//   m_valid    m_data carries a frame byte this cycle
//   m_sof      first byte of a frame
//   m_eof      last byte of a frame
//   m_err      frame is bad; meaningful only with m_eof
//   crc_err    FCS mismatch; meaningful only with m_eof
//   frame_cnt  good frames delivered (wraps)
//   err_cnt    bad frames and runts (wraps)
// -----------------------------------------------------------------------------
module rgmii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk_div,
  input  logic        reset,
  input  logic [7:0]  rxd,
  input  logic        rxdv,
  input  logic        rxer,
  input  logic        ibs_up,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eof,
  output logic        m_err,
  output logic        crc_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  // Delay line depth: the last payload byte plus the 4 FCS bytes.
  localparam int          DLY       = 5;
  localparam logic [7:0]  PRE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE  = 8'hD5;
  localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [15:0] DLY_W     = 16'(DLY);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t      state_reg;
  logic [15:0] byte_cnt_reg;     // bytes after the SFD, saturating
  logic        sof_pending_reg;  // the next emitted byte opens the frame
  logic        rxer_seen_reg;    // sticky rxer within the current frame
  logic        idle_seen_reg;    // rxdv=0 seen at least once since reset

  logic        shift_en;
  logic        link_abort;
  logic        frame_end;
  logic        have_five;
  logic        len_bad;
  logic        crc_bad;
  logic        eof_err;
  logic [15:0] byte_cnt_inc;
  logic [7:0]  oldest;

  // A byte enters the frame only while the link is up. A sample taken with
  // ibs_up=0 closes the frame and is not buffered.
  assign shift_en   = (state_reg == DATA) && rxdv && ibs_up;

  // In PREAMBLE, rxdv=0 is an ordinary return to IDLE. A link drop counts as
  // an abort only while a frame is actually being signalled.
  assign link_abort = !ibs_up &&
                      ((state_reg == DATA) || ((state_reg == PREAMBLE) && rxdv));
  assign frame_end  = ((state_reg == DATA) && !rxdv) || link_abort;

  assign have_five    = (byte_cnt_reg >= DLY_W);
  assign byte_cnt_inc = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg
                                                   : byte_cnt_reg + 16'd1;
  assign len_bad      = (byte_cnt_reg < MIN_LEN_W) || (byte_cnt_reg > MAX_LEN_W);
  assign eof_err      = rxer_seen_reg | crc_bad | len_bad | link_abort;

  // ---------------------------------------------------------------------------
  // 5-byte delay line. Stage 0 takes the newest byte, and stage DLY-1 holds the
  // oldest byte, which is the next one to be emitted.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DLY; gi++) begin : g_dly
    logic [7:0] stage_reg;
    logic [7:0] stage_in;

    if (gi == 0) begin : g_head
      assign stage_in = rxd;
    end else begin : g_tail
      assign stage_in = g_dly[gi-1].stage_reg;
    end

    always_ff @(posedge clk_div or posedge reset) begin
      if (reset) begin
        stage_reg <= 8'h00;
      end else if (shift_en) begin
        stage_reg <= stage_in;
      end
    end
  end

  assign oldest = g_dly[DLY-1].stage_reg;

  // ---------------------------------------------------------------------------
  // Optional CRC-32 over every byte after the SFD
  // ---------------------------------------------------------------------------
`ifdef RGMII_RX_CRC_CHECK_EN
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [31:0] crc_reg;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data_in);
    logic [31:0] c;
    c = crc_in ^ {24'h000000, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      crc_reg <= CRC_INIT;
    end else if ((state_reg == PREAMBLE) && rxdv && ibs_up && (rxd == SFD_BYTE)) begin
      crc_reg <= CRC_INIT;
    end else if (shift_en) begin
      crc_reg <= crc32_byte(crc_reg, rxd);
    end
  end

  // When the FCS is included, an intact frame leaves the fixed residue.
  assign crc_bad = (crc_reg != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM with registered stream outputs and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_div or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= 16'd0;
      sof_pending_reg <= 1'b0;
      rxer_seen_reg   <= 1'b0;
      idle_seen_reg   <= 1'b0;
      m_data          <= 8'h00;
      m_valid         <= 1'b0;
      m_sof           <= 1'b0;
      m_eof           <= 1'b0;
      m_err           <= 1'b0;
      crc_err         <= 1'b0;
      frame_cnt       <= 16'd0;
      err_cnt         <= 16'd0;
    end else begin
      // The stream outputs are single-cycle pulses that default to zero.
      m_data  <= 8'h00;
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
      m_err   <= 1'b0;
      crc_err <= 1'b0;

      // Reset can be released in the middle of a frame. Until a gap has been
      // seen, any activity is treated as the tail of that frame and dropped.
      if (!rxdv) begin
        idle_seen_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (ibs_up && rxdv) begin
            if ((rxd == PRE_BYTE) && idle_seen_reg) begin
              state_reg    <= PREAMBLE;
              byte_cnt_reg <= 16'd0;
            end else begin
              state_reg <= DROP;
            end
          end
        end

        PREAMBLE: begin
          if (!rxdv) begin
            state_reg <= IDLE;
          end else if (!ibs_up) begin
            // A link drop before any data counts as a runt.
            err_cnt   <= err_cnt + 16'd1;
            state_reg <= IDLE;
          end else if (rxd == SFD_BYTE) begin
            state_reg       <= DATA;
            byte_cnt_reg    <= 16'd0;
            sof_pending_reg <= 1'b1;
            rxer_seen_reg   <= 1'b0;
          end else if (rxd != PRE_BYTE) begin
            state_reg <= DROP;
          end
        end

        DATA: begin
          if (frame_end) begin
            state_reg       <= IDLE;
            byte_cnt_reg    <= 16'd0;
            sof_pending_reg <= 1'b0;
            if (have_five) begin
              m_valid <= 1'b1;
              m_data  <= oldest;
              m_sof   <= sof_pending_reg;
              m_eof   <= 1'b1;
              m_err   <= eof_err;
              crc_err <= crc_bad;
              if (eof_err) begin
                err_cnt <= err_cnt + 16'd1;
              end else begin
                frame_cnt <= frame_cnt + 16'd1;
              end
            end else begin
              // Too short to contain an FCS: count it and emit nothing.
              err_cnt <= err_cnt + 16'd1;
            end
          end else begin
            // Here rxdv=1 and ibs_up=1, which is exactly when shift_en is set.
            byte_cnt_reg <= byte_cnt_inc;
            if (rxer) begin
              rxer_seen_reg <= 1'b1;
            end
            if (have_five) begin
              m_valid         <= 1'b1;
              m_data          <= oldest;
              m_sof           <= sof_pending_reg;
              sof_pending_reg <= 1'b0;
            end
          end
        end

        DROP: begin
          if (!rxdv) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rgmii_rx_framer.md
RGMII_RX_FRAMER -- requirements
Module: rgmii_rx_framer

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, minimum frame length in bytes after the SFD, including the FCS.
REQ-002 SHALL have parameter MAX_LEN, default 1518, maximum frame length in bytes after the SFD, including the FCS.
REQ-003 SHALL have the following ports:
- clk_div  in  1  GMII receive clock from the RGMII receiver (125/25/2.5 MHz).
- reset  in  1  asynchronous reset, active-high.
- rxd  in  8  GMII receive data.
- rxdv  in  1  GMII data valid.
- rxer  in  1  GMII receive error.
- ibs_up  in  1  in-band link status (1 = up).
- m_data  out  8  frame byte; preamble, SFD and FCS are stripped.
- m_valid  out  1  m_data is valid this cycle.
- m_sof  out  1  first byte of the frame.
- m_eof  out  1  last byte of the frame.
- m_err  out  1  frame is bad; valid only when m_eof=1.
- crc_err  out  1  FCS mismatch; valid only when m_eof=1.
- frame_cnt  out  16  count of good frames.
- err_cnt  out  16  count of bad or runt frames.

Function
REQ-004 SHALL implement the FSM states IDLE, PREAMBLE, DATA and DROP, each sampled on the rising edge of clk_div.
REQ-005 IDLE SHALL transition as follows:
- rxdv=1 and rxd=0x55 -> PREAMBLE.
- rxdv=1 and any other rxd -> DROP.
REQ-006 PREAMBLE SHALL transition as follows:
- rxdv=0 -> IDLE.
- rxd=0x55 -> stay in PREAMBLE.
- rxd=0xD5 -> DATA.
- any other rxd -> DROP.
REQ-007 DROP SHALL return to IDLE on the first sample with rxdv=0, and SHALL produce no output.
REQ-008 In DATA, each sample with rxdv=1 SHALL shift rxd into a 5-byte delay line and increment a byte counter.
- The byte counter is 16-bit and saturates at 0xFFFF.
REQ-009 Once the delay line holds 5 bytes, each new byte SHALL cause the oldest byte to be output on the next cycle with m_valid=1.
- Latency: byte N after the SFD appears one cycle after byte N+5 is sampled.
REQ-010 m_sof SHALL be 1 together with the first m_valid of each frame.
REQ-011 In DATA, the first sample with rxdv=0 SHALL end the frame.
- If the byte count is at least 5: on the next cycle, output the oldest buffered byte with m_valid=1 and m_eof=1; the remaining 4 bytes are the FCS and are discarded.
- If the byte count is below 5: the frame is a runt; no output; err_cnt increments.
- In both cases the FSM returns to IDLE.
REQ-012 If a frame is exactly 5 bytes, its single output byte SHALL carry both m_sof=1 and m_eof=1.
REQ-013 m_err SHALL equal the OR of the following, evaluated at m_eof:
- rxer=1 seen in any DATA sample (sticky);
- crc_err;
- byte count < MIN_LEN;
- byte count > MAX_LEN;
- link abort (REQ-014).
REQ-014 ibs_up=0 in PREAMBLE or DATA SHALL act as end of frame (REQ-011) with m_err forced to 1; ibs_up=0 in IDLE SHALL hold IDLE.
REQ-015 m_data, m_sof, m_eof, m_err and crc_err SHALL be 0 whenever m_valid=0.
REQ-016 At each m_eof, frame_cnt SHALL increment if m_err=0, otherwise err_cnt SHALL increment; both counters wrap modulo 2^16.
REQ-017 rxdv=1 on the cycle immediately after a frame end SHALL be handled from IDLE without any sample being lost.

Reset
REQ-018 While reset=1, all outputs and counters SHALL be 0, the FSM SHALL be in IDLE, and the delay line and CRC state SHALL be cleared.
REQ-019 A frame in progress when reset asserts SHALL be discarded with no m_eof.
- After reset releases with rxdv=1, the FSM enters DROP until rxdv=0.

Configuration
REQ-020 With macro RGMII_RX_CRC_CHECK_EN defined, the block SHALL run CRC-32 over every byte after the SFD, including the FCS.
- Polynomial: reflected 0xEDB88320; initial value 0xFFFFFFFF.
- crc_err=1 at m_eof when the final register value is not 0xDEBB20E3.
REQ-021 Without RGMII_RX_CRC_CHECK_EN, the block SHALL contain no CRC logic and crc_err SHALL be tied 0; FCS stripping is unchanged.

Verification
REQ-022 7x0x55, 0xD5, 60 payload bytes 0x00..0x3B, valid FCS, then rxdv=0 -> 60 outputs 0x00..0x3B; m_sof on 0x00; m_eof on 0x3B; m_err=0; frame_cnt=1.
REQ-023 Same frame with FCS byte 0 XOR 0x01, macro defined -> m_eof with crc_err=1 and m_err=1; err_cnt=1; macro undefined -> m_err=0 and frame_cnt=1.
REQ-024 Valid 64-byte frame with rxer=1 on payload byte 20 -> m_err=1 at eof; err_cnt=1.
REQ-025 0x55, 0x55, 0x5D, 0xD5, then 20 bytes -> no m_valid; FSM back in IDLE; counters unchanged. 0xD5 followed by 3 bytes -> no m_valid; err_cnt increments by 1.
REQ-026 ibs_up=0 at payload byte 30 -> next cycle m_eof=1 and m_err=1. Reset at payload byte 30 -> all outputs 0. Next valid frame -> received intact.
REQ-027 Two back-to-back 64-byte frames with 1-cycle rxdv gap -> both delivered; frame_cnt=2.
